// File: rtl/instr_decode_queue.sv
// Decoding instruction queue: splits raw instructions into fields and flags at
// push, stores decoded entries in a FIFO and issues them behind a SYNC barrier.
// Ports: clk, rst_n (async, active-low); fetch_* valid/ready push side;
// issue_* valid/ready pop side with decoded fields and class flags;
// sync_done releases the barrier; queue_count is occupancy;
// illegal_instr / illegal_count report dropped opcodes.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN (drop illegal opcodes).

package instruction_pkg;
  typedef enum logic [3:0] {
    NOP     = 4'h0,
    MLOAD   = 4'h1,
    MSTORE  = 4'h2,
    MMULT   = 4'h3,
    MADD    = 4'h4,
    DMA_ST  = 4'h5,
    DMA_CHK = 4'h6,
    SYNC    = 4'h7
  } opcode_t;
endpackage

module instr_decode_queue
  import instruction_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int REG_W   = 4,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INSTR_W-1:0]           fetch_instruction,
  input  logic                         fetch_valid,
  output logic                         fetch_ready,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [3:0]                   issue_opcode,
  output logic [REG_W-1:0]             issue_rd,
  output logic [REG_W-1:0]             issue_rs1,
  output logic [REG_W-1:0]             issue_rs2,
  output logic [INSTR_W-4-3*REG_W-1:0] issue_imm,
  output logic                         issue_is_matrix_op,
  output logic                         issue_uses_dma,
  output logic                         issue_needs_sync,
  input  logic                         sync_done,
  output logic [$clog2(DEPTH):0]       queue_count,
  output logic                         illegal_instr,
  output logic [7:0]                   illegal_count
);

  localparam int IMM_W = INSTR_W - 4 - 3 * REG_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [3:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
    logic             mat;
    logic             dma;
    logic             sync;
  } entry_t;

  typedef enum logic {
    RUN       = 1'b0,
    SYNC_WAIT = 1'b1
  } state_t;

  entry_t             mem_q [DEPTH];
  entry_t             dec;
  entry_t             head;
  entry_t             out;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  state_t             state_q;
  logic               push;
  logic               wr_en;
  logic               pop;

  always_comb begin
    dec     = '0;
    dec.op  = fetch_instruction[INSTR_W-1 -: 4];
    dec.rd  = fetch_instruction[INSTR_W-5 -: REG_W];
    dec.rs1 = fetch_instruction[INSTR_W-5-REG_W -: REG_W];
    dec.rs2 = fetch_instruction[INSTR_W-5-2*REG_W -: REG_W];
    dec.imm = fetch_instruction[IMM_W-1:0];
    case (dec.op)
      MLOAD, MSTORE, MMULT, MADD: dec.mat  = 1'b1;
      DMA_ST, DMA_CHK:            dec.dma  = 1'b1;
      SYNC:                       dec.sync = 1'b1;
      default: ;
    endcase
  end

  assign fetch_ready = (count_q < CNT_W'(DEPTH));
  assign issue_valid = (count_q != '0) && (state_q == RUN);
  assign push        = fetch_valid && fetch_ready;
  assign pop         = issue_valid && issue_ready;
  assign head        = mem_q[rd_ptr_q];

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic       legal;
  logic       ill_q;
  logic [7:0] ill_cnt_q;

  always_comb begin
    legal = 1'b0;
    case (dec.op)
      NOP, MLOAD, MSTORE, MMULT,
      MADD, DMA_ST, DMA_CHK, SYNC: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Accepted-but-illegal instructions are consumed and never stored.
  assign wr_en = push && legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q     <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      ill_q <= push && !legal;
      if (push && !legal && ill_cnt_q != 8'hFF)
        ill_cnt_q <= ill_cnt_q + 8'd1;
    end
  end

  assign illegal_instr = ill_q;
  assign illegal_count = ill_cnt_q;
`else
  assign wr_en         = push;
  assign illegal_instr = 1'b0;
  assign illegal_count = 8'd0;
`endif

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= dec;
  end

  // Pops only happen in RUN, so a sync_done coincident with
  // the SYNC pop is seen in RUN and ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      unique case (state_q)
        RUN:
          if (pop && head.sync)
            state_q <= SYNC_WAIT;
        SYNC_WAIT:
          if (sync_done)
            state_q <= RUN;
        default:
          state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    out = '0;
    if (issue_valid)
      out = head;
  end

  assign issue_opcode       = out.op;
  assign issue_rd           = out.rd;
  assign issue_rs1          = out.rs1;
  assign issue_rs2          = out.rs2;
  assign issue_imm          = out.imm;
  assign issue_is_matrix_op = out.mat;
  assign issue_uses_dma     = out.dma;
  assign issue_needs_sync   = out.sync;
  assign queue_count        = count_q;

endmodule
